sys_mem_resp: RTL and testbench

SYS_MEM_RESP -- requirements
Module: sys_mem_resp

---
 rtl/sys_mem_resp_pkg.sv | 25 ++
 rtl/sys_mem_req_ff.sv | 68 ++++++
 rtl/sys_mem_resp.sv | 211 +++++++++++++++++++++
 tb/tb_sys_mem_resp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_mem_resp_pkg.sv
// sys_mem_resp_pkg: shared types for the system memory responder.
//   state_e     - service FSM states
//   req_entry_t - one queued request {is_wr, addr, wdata}
// The request bus widths are fixed here. The top checks that its width
// parameters match them during elaboration.
package sys_mem_resp_pkg;

    localparam int unsigned REQ_DATA_W  = 32;
    localparam int unsigned REQ_ADDR_W  = 27;
    localparam int unsigned SVC_CNT_W   = 4;
    localparam int unsigned REQ_ENTRY_W = 1 + REQ_ADDR_W + REQ_DATA_W;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess
    } state_e;

    typedef struct packed {
        logic                  is_wr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_entry_t;

endpackage

// File: rtl/sys_mem_req_ff.sv
// sys_mem_req_ff: synchronous FIFO for memory requests.
// The head entry is presented combinationally on rdata.
//   clk, rst      - clock and synchronous active-high reset (pointers/count only)
//   push, wdata   - enqueue (ignored when full unless a pop happens the same cycle)
//   pop, rdata    - dequeue and head entry (pop ignored when empty)
//   full, empty   - occupancy flags
//   count         - number of valid entries
module sys_mem_req_ff #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sys_mem_resp.sv
// sys_mem_resp: emulated system memory responder.
// Requests are queued in a FIFO and serviced in order by a three-state FSM
// that inserts SVC_CYCLES wait-states before each access to a single-port
// backing array. Reads return one cntrlr_rd_valid strobe with registered data.
//   clk, rst          - clock and synchronous active-high reset
//   cntrlr_wait       - back-pressure: FIFO full or in reset
//   cntrlr_wren/rden  - write/read request (both set: treated as write)
//   cntrlr_addr/wdata - word address and write data
//   cntrlr_rd_valid   - one-cycle read response strobe
//   cntrlr_rdata      - read data, held between responses
//   proto_err         - sticky flag for simultaneous wren and rden
module sys_mem_resp
    import sys_mem_resp_pkg::*;
#(
    parameter int unsigned           MEM_DATA_W       = 32,
    parameter int unsigned           MEM_ADDR_W       = 27,
    parameter int unsigned           MEM_DEPTH_W      = 10,
    parameter int unsigned           REQ_FF_DEPTH     = 4,
    parameter int unsigned           SVC_CYCLES       = 2,
    parameter logic [MEM_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cntrlr_wait,
    input  logic                  cntrlr_wren,
    input  logic                  cntrlr_rden,
    input  logic [MEM_ADDR_W-1:0] cntrlr_addr,
    input  logic [MEM_DATA_W-1:0] cntrlr_wdata,
    output logic                  cntrlr_rd_valid,
    output logic [MEM_DATA_W-1:0] cntrlr_rdata,
    output logic                  proto_err
);

    localparam int unsigned CNT_W = $clog2(REQ_FF_DEPTH) + 1;
    localparam logic [SVC_CNT_W-1:0] SVC_LOAD = SVC_CNT_W'(SVC_CYCLES);
    // Back-to-back reload is one shorter so that, with the ACCESS cycle,
    // a busy engine completes one request every SVC_CYCLES+1 cycles.
    localparam logic [SVC_CNT_W-1:0] SVC_RELOAD =
        (SVC_CYCLES == 0) ? '0 : SVC_CNT_W'(SVC_CYCLES - 1);

    if (MEM_DATA_W != REQ_DATA_W || MEM_ADDR_W != REQ_ADDR_W) begin : g_bad_width
        $error("sys_mem_resp: bus width parameters must match sys_mem_resp_pkg");
    end

    // Request queue
    req_entry_t              push_entry;
    req_entry_t              head_entry;
    logic [REQ_ENTRY_W-1:0]  head_bits;
    logic                    req_accept;
    logic                    ff_pop;
    logic                    ff_full;
    logic                    ff_empty;
    logic [CNT_W-1:0]        ff_count;

    assign cntrlr_wait = rst || ff_full;
    assign req_accept  = (cntrlr_wren || cntrlr_rden) && !cntrlr_wait;
    assign head_entry  = req_entry_t'(head_bits);

    always_comb begin
        push_entry.is_wr = cntrlr_wren;
        push_entry.addr  = cntrlr_addr;
        push_entry.wdata = cntrlr_wdata;
    end

    sys_mem_req_ff #(
        .WIDTH (REQ_ENTRY_W),
        .DEPTH (REQ_FF_DEPTH)
    ) u_req_ff (
        .clk   (clk),
        .rst   (rst),
        .push  (req_accept),
        .wdata (push_entry),
        .pop   (ff_pop),
        .rdata (head_bits),
        .full  (ff_full),
        .empty (ff_empty),
        .count (ff_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ff_full == (ff_count == CNT_W'(REQ_FF_DEPTH)));
        end
    end

    // Service FSM
    state_e               state_q;
    state_e               state_d;
    logic [SVC_CNT_W-1:0] wait_cnt_q;
    logic [SVC_CNT_W-1:0] wait_cnt_d;
    logic                 acc_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!ff_empty) begin
                    state_d    = StWait;
                    wait_cnt_d = SVC_LOAD;
                end
            end
            StWait: begin
                if (wait_cnt_q == '0) begin
                    state_d = StAccess;
                end else begin
                    wait_cnt_d = wait_cnt_q - SVC_CNT_W'(1);
                end
            end
            StAccess: begin
                if (ff_empty) begin
                    state_d = StIdle;
                end else if (SVC_CYCLES == 0) begin
                    state_d = StAccess;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = SVC_RELOAD;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ff_pop = 1'b0;
        acc_en = 1'b0;
        unique case (state_q)
            StIdle:   ff_pop = !ff_empty;
            StWait:   ff_pop = 1'b0;
            StAccess: begin
                acc_en = 1'b1;
                ff_pop = !ff_empty;
            end
            default:  ff_pop = 1'b0;
        endcase
    end

    // Entry being serviced, latched as it leaves the FIFO
    req_entry_t cur_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
        end else if (ff_pop) begin
            cur_q <= head_entry;
        end
    end

    // Backing array: single port, one access per ACCESS cycle
    logic [MEM_DATA_W-1:0]  mem_q [2**MEM_DEPTH_W];
    logic [MEM_DEPTH_W-1:0] mem_idx;
    logic                   in_range;
    logic                   mem_we;
    logic                   mem_re;
    logic [MEM_DATA_W-1:0]  mem_rd_q;
    logic                   oor_q;
    logic                   rd_valid_q;
    logic                   proto_err_q;

    assign mem_idx  = cur_q.addr[MEM_DEPTH_W-1:0];
    assign in_range = (cur_q.addr[MEM_ADDR_W-1:MEM_DEPTH_W] == '0);
    assign mem_we   = acc_en && cur_q.is_wr && in_range;
    assign mem_re   = acc_en && !cur_q.is_wr;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= cur_q.wdata;
        end
    end

    // Out-of-range reads still clock the RAM; the flag swaps in the default
    // value so the RAM output register stays a plain enable/reset register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_q   <= '0;
            oor_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= mem_re;
            if (mem_re) begin
                mem_rd_q <= mem_q[mem_idx];
                oor_q    <= !in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (req_accept && cntrlr_wren && cntrlr_rden) begin
            proto_err_q <= 1'b1;
        end
    end

    assign cntrlr_rd_valid = rd_valid_q;
    assign cntrlr_rdata    = oor_q ? DEFAULT_DATA_VAL : mem_rd_q;
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_sys_mem_resp.sv
// Directed bench for sys_mem_resp: one instance with SVC_CYCLES=2, one with 0.
module tb_sys_mem_resp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 27;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          a_wait, a_wren, a_rden, a_rd_valid, a_proto_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_wait, b_wren, b_rden, b_rd_valid, b_proto_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;

    sys_mem_resp #(.SVC_CYCLES(2)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .cntrlr_wait     (a_wait),
        .cntrlr_wren     (a_wren),
        .cntrlr_rden     (a_rden),
        .cntrlr_addr     (a_addr),
        .cntrlr_wdata    (a_wdata),
        .cntrlr_rd_valid (a_rd_valid),
        .cntrlr_rdata    (a_rdata),
        .proto_err       (a_proto_err)
    );

    sys_mem_resp #(.SVC_CYCLES(0)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .cntrlr_wait     (b_wait),
        .cntrlr_wren     (b_wren),
        .cntrlr_rden     (b_rden),
        .cntrlr_addr     (b_addr),
        .cntrlr_wdata    (b_wdata),
        .cntrlr_rd_valid (b_rd_valid),
        .cntrlr_rdata    (b_rdata),
        .proto_err       (b_proto_err)
    );

    // Response logs: data and the cycle count at which rd_valid was seen
    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [31:0] qb_data[$];
    int          qb_cyc[$];

    always @(negedge clk) begin
        if (a_rd_valid === 1'b1) begin
            qa_data.push_back(a_rdata);
            qa_cyc.push_back(cyc);
        end
        if (b_rd_valid === 1'b1) begin
            qb_data.push_back(b_rdata);
            qb_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa_at(input int i);
        if (i < qa_data.size()) return qa_data[i];
        return 'x;
    endfunction

    function automatic int qa_cyc_at(input int i);
        if (i < qa_cyc.size()) return qa_cyc[i];
        return -1000;
    endfunction

    function automatic logic [31:0] qb_at(input int i);
        if (i < qb_data.size()) return qb_data[i];
        return 'x;
    endfunction

    function automatic int qb_cyc_at(input int i);
        if (i < qb_cyc.size()) return qb_cyc[i];
        return -1000;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        a_wren = 1'b0;
        a_rden = 1'b0;
        b_wren = 1'b0;
        b_rden = 1'b0;
    endtask

    // Present a request and hold it until accepted. Returns the cycle of the
    // accepting edge and cntrlr_wait just after it. Leaves the request driven
    // so that the next call follows back-to-back.
    task automatic issue(input bit use_b, input bit wr, input bit rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output int acc_cyc, output logic wait_after);
        int   n;
        logic w;
        n = 0;
        if (use_b) begin
            b_wren = wr; b_rden = rd; b_addr = addr; b_wdata = data;
        end else begin
            a_wren = wr; a_rden = rd; a_addr = addr; a_wdata = data;
        end
        do begin
            @(negedge clk);
            w = use_b ? b_wait : a_wait;
            n++;
        end while (w !== 1'b0 && n < 50);
        check_eq("accept_in_bound", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        wait_after = use_b ? b_wait : a_wait;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        int   acc0;
        logic w;
        logic wa [6];

        rst = 1'b1;
        go_idle();
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_wait", 32'(a_wait), 32'd1);
        check_eq("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        check_eq("rst_rdata", a_rdata, 32'd0);
        check_eq("rst_proto_err", 32'(a_proto_err), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("wait_after_rst", 32'(a_wait), 32'd0);

        // Preload addr 0 and 21..25
        issue(0, 1, 0, 0, 32'h0000_0f00, acc, w);
        for (int i = 21; i <= 25; i++) issue(0, 1, 0, AW'(i), 32'ha500_0000 | i, acc, w);
        go_idle();
        wait_cycles(30);

        // Write then read back on an idle block: latency 5
        issue(0, 1, 0, 5, 32'h1234_5678, acc, w);
        go_idle();
        wait_cycles(10);
        qa_data.delete(); qa_cyc.delete();
        issue(0, 0, 1, 5, 0, acc, w);
        go_idle();
        wait_cycles(10);
        check_eq("rd5_count", 32'(qa_data.size()), 32'd1);
        check_eq("rd5_data", qa_at(0), 32'h1234_5678);
        check_eq("rd5_latency", 32'(qa_cyc_at(0) - acc), 32'd5);
        wait_cycles(3);
        check_eq("rdata_hold", a_rdata, 32'h1234_5678);
        check_eq("rd_valid_low", 32'(a_rd_valid), 32'd0);

        // A write followed by 6 back-to-back reads. The write is popped on
        // the first read's edge, so the 4th read fills all 4 entries.
        qa_data.delete(); qa_cyc.delete();
        issue(0, 1, 0, 20, 32'hcafe_0020, acc, w);
        for (int i = 0; i < 6; i++) begin
            issue(0, 0, 1, AW'(20 + i), 0, acc, w);
            wa[i] = w;
        end
        go_idle();
        wait_cycles(40);
        check_eq("b2b_wait_after_3rd", 32'(wa[2]), 32'd0);
        check_eq("b2b_wait_after_4th", 32'(wa[3]), 32'd1);
        check_eq("b2b_count", 32'(qa_data.size()), 32'd6);
        check_eq("b2b_data0", qa_at(0), 32'hcafe_0020);
        for (int i = 1; i < 6; i++) begin
            check_eq($sformatf("b2b_data%0d", i), qa_at(i), 32'ha500_0000 | (20 + i));
            check_eq($sformatf("b2b_spacing%0d", i), 32'(qa_cyc_at(i) - qa_cyc_at(i - 1)), 32'd3);
        end

        // Out-of-range read, and an out-of-range write that must not alias
        qa_data.delete(); qa_cyc.delete();
        issue(0, 0, 1, 27'h400, 0, acc, w);
        go_idle();
        wait_cycles(10);
        check_eq("oor_count", 32'(qa_data.size()), 32'd1);
        check_eq("oor_data", qa_at(0), 32'hdead_babe);
        qa_data.delete(); qa_cyc.delete();
        issue(0, 1, 0, 27'h400, 32'h0000_00aa, acc, w);
        issue(0, 0, 1, 0, 0, acc, w);
        go_idle();
        wait_cycles(15);
        check_eq("alias_count", 32'(qa_data.size()), 32'd1);
        check_eq("alias_addr0", qa_at(0), 32'h0000_0f00);

        // Simultaneous wren and rden: treated as a write, sticky error
        qa_data.delete(); qa_cyc.delete();
        issue(0, 1, 1, 3, 32'h0000_0055, acc, w);
        go_idle();
        wait_cycles(1);
        check_eq("proto_err_set", 32'(a_proto_err), 32'd1);
        wait_cycles(10);
        check_eq("proto_no_rd_valid", 32'(qa_data.size()), 32'd0);
        issue(0, 0, 1, 3, 0, acc, w);
        go_idle();
        wait_cycles(10);
        check_eq("proto_rd3", qa_at(0), 32'h0000_0055);
        check_eq("proto_err_sticky", 32'(a_proto_err), 32'd1);

        // Reset pulse with 3 reads queued
        issue(0, 1, 0, 7, 32'h0000_7777, acc, w);
        go_idle();
        wait_cycles(10);
        qa_data.delete(); qa_cyc.delete();
        for (int i = 0; i < 3; i++) issue(0, 0, 1, 7, 0, acc, w);
        go_idle();
        rst = 1'b1;
        wait_cycles(1);
        check_eq("midrst_wait_high", 32'(a_wait), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("midrst_wait_low", 32'(a_wait), 32'd0);
        check_eq("midrst_proto_err", 32'(a_proto_err), 32'd0);
        check_eq("midrst_rdata", a_rdata, 32'd0);
        wait_cycles(20);
        check_eq("midrst_no_rd_valid", 32'(qa_data.size()), 32'd0);
        issue(0, 0, 1, 7, 0, acc, w);
        go_idle();
        wait_cycles(10);
        check_eq("midrst_rd7", qa_at(0), 32'h0000_7777);

        // SVC_CYCLES=0: continuous reads stream out every cycle
        for (int i = 0; i < 8; i++) issue(1, 1, 0, AW'(i), 32'hb000_0000 | i, acc, w);
        go_idle();
        wait_cycles(15);
        qb_data.delete(); qb_cyc.delete();
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, 0, 1, AW'(i), 0, acc, w);
            if (i == 0) acc0 = acc;
        end
        go_idle();
        wait_cycles(15);
        check_eq("svc0_count", 32'(qb_data.size()), 32'd8);
        check_eq("svc0_latency", 32'(qb_cyc_at(0) - acc0), 32'd3);
        check_eq("svc0_data0", qb_at(0), 32'hb000_0000);
        for (int i = 1; i < 8; i++) begin
            check_eq($sformatf("svc0_data%0d", i), qb_at(i), 32'hb000_0000 | i);
            check_eq($sformatf("svc0_spacing%0d", i), 32'(qb_cyc_at(i) - qb_cyc_at(i - 1)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
